psram_word_bridge: RTL
======================

# psram_word_bridge

Converts the CPU system's 32-bit PSRAM word interface (single-cycle `rd`/`wr` strobes plus a `busy` handshake) into two sequential 16-bit half-word accesses on the CRAM0 controller's request/acknowledge port. It sits between `cpu_system` and the CRAM0 half-word controller in `core_top`, running on the 133 MHz CPU clock. It owns word splitting and reassembly and the `busy` protocol the CPU waits on, and optionally a hang timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: cycles one half access may wait for `hw_ack` before abort. Used only with the timeout feature; valid range 1..4095.

Ports:
- `clk`  in  1  clock (133 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `word_rd`  in  1  one-cycle read strobe
- `word_wr`  in  1  one-cycle write strobe
- `word_addr`  in  22  word address
- `word_wdata`  in  32  write data, sampled with `word_wr`
- `word_rdata`  out  32  read data, valid when `busy` falls after a read
- `word_busy`  out  1  transaction in progress
- `hw_req`  out  1  half-word request, level, held until acked
- `hw_we`  out  1  half-word write
- `hw_addr`  out  23  half-word address
- `hw_wdata`  out  16  half-word write data
- `hw_rdata`  in  16  half-word read data, valid with `hw_ack`
- `hw_ack`  in  1  one-cycle completion pulse
- `err`  out  1  sticky timeout flag
- `err_clr`  in  1  clears `err`

## Operation
- States: IDLE, LO, GAP, HI. All outputs are registered.
- IDLE: on `word_wr` or `word_rd`, latch address, data and direction. Go to LO with `word_busy`=1, `hw_req`=1, `hw_addr`={addr,1'b0}, `hw_wdata`=wdata[15:0]. If both strobes are high together, the write wins.
- LO: on `hw_ack`, capture `hw_rdata` into lo (reads only). Go to GAP with `hw_req`=0.
- GAP: one cycle. Go to HI with `hw_req`=1, `hw_addr`={addr,1'b1}, `hw_wdata`=wdata[31:16].
- HI: on `hw_ack`, go to IDLE with `hw_req`=0 and `word_busy`=0. For reads, `word_rdata`={hw_rdata, lo} is loaded on the same edge.
- `hw_we` is constant for the whole transaction and equals the latched direction.
- `word_rdata` holds its value until the next read completes. Writes never change it.
- Strobes seen outside IDLE are ignored (dropped, not queued).
- `hw_ack` while `hw_req`=0 is ignored.
- Little-endian split: the low half goes to the even half-word address. Address 0x3FFFFF maps to half-words 0x7FFFFE/0x7FFFFF; there is no wrap inside a word.

## Timing
- Reset values: `word_busy`=0, `word_rdata`=0, `hw_req`=0, `hw_we`=0, `hw_addr`=0, `hw_wdata`=0, `err`=0, state IDLE. Reset mid-transaction drops `hw_req` immediately (asynchronous) and abandons the access.
- Strobe sampled at edge T: `word_busy`=1 and `hw_req`=1 from T+1. `word_busy` is never low the cycle after an accepted strobe, which the CPU relies on to see busy rise.
- Ack of the low half sampled at edge A: `hw_req`=0 at A+1, high half requested at A+2.
- Ack of the high half sampled at edge B: `word_busy`=0 and data valid at B+1.
- Minimum latency is 4 cycles from strobe to `busy` low, with ack in the first request cycle each time.
- `err_clr` and a timeout in the same cycle: `err` ends at 1 (set wins).

## Configuration
- `PSRAM_BRIDGE_TIMEOUT_EN` defined:
  - A 12-bit counter resets on each half-request issue and counts while in LO or HI.
  - When it reaches `TIMEOUT_CYCLES` without ack, the next edge goes to IDLE with `hw_req`=0, `word_busy`=0 and `err`=1.
  - For a read, `word_rdata`=32'hDEADBEEF. A write is abandoned with `word_rdata` unchanged.
  - A late `hw_ack` arriving in IDLE is ignored.
- Not defined: no counter is built, the bridge waits indefinitely, and `err` is constant 0 (`err_clr` unused).

## Test plan
- Write 0x12345678 to word 0x000010, ack after 3 cycles per half -> half writes 0x5678 at 0x000020 then 0x1234 at 0x000021, `hw_we`=1, one GAP cycle between them, `busy` high 1 cycle after the strobe and low 1 cycle after the second ack.
- Read word 0x3FFFFF, return 0xBEEF then 0xCAFE with ack in the request cycle -> addresses 0x7FFFFE/0x7FFFFF, `word_rdata`=0xCAFEBEEF, `busy` low exactly 4 cycles after the strobe.
- Issue a read strobe while busy, plus a stray `hw_ack` during GAP -> second strobe ignored, no extra `hw_req`, GAP still lasts exactly 1 cycle, transaction completes normally.
- Simultaneous `word_rd` and `word_wr` with wdata 0xA5A55A5A -> a write of 0x5A5A then 0xA5A5, `word_rdata` unchanged.
- Assert reset while in HI -> `hw_req` and `busy` drop before the next edge. A following read completes correctly.
- With `PSRAM_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no ack -> abort after 8 wait cycles, `word_rdata`=0xDEADBEEF, `err`=1 until `err_clr` is pulsed. Without the macro -> still busy after 10000 cycles, `err`=0.

Source files
------------

// File: rtl/psram_word_bridge.sv
// psram_word_bridge: splits 32-bit CPU PSRAM word accesses into two sequential
// 16-bit half-word request/acknowledge accesses (low half at the even address
// first) and reassembles read data. All outputs are registered.
// Optional feature macro: PSRAM_BRIDGE_TIMEOUT_EN adds a per-half ack timeout
// that aborts the access, returns 32'hDEADBEEF on reads and sets sticky err.
module psram_word_bridge #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_rd,
    input  logic        word_wr,
    input  logic [21:0] word_addr,
    input  logic [31:0] word_wdata,
    output logic [31:0] word_rdata,
    output logic        word_busy,
    output logic        hw_req,
    output logic        hw_we,
    output logic [22:0] hw_addr,
    output logic [15:0] hw_wdata,
    input  logic [15:0] hw_rdata,
    input  logic        hw_ack,
    output logic        err,
    input  logic        err_clr
);

    localparam logic [11:0] TO_LIMIT = 12'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_GAP, ST_HI} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_lo;
    logic [21:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic [15:0] w_lo_nxt;
    logic        w_busy_nxt;
    logic        w_req_nxt;
    logic        w_we_nxt;
    logic [22:0] w_hw_addr_nxt;
    logic [15:0] w_hw_wdata_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_timeout;

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
    logic [11:0] r_cnt;
    logic        r_err;

    assign w_timeout = ((r_state == ST_LO) || (r_state == ST_HI)) && !hw_ack && (r_cnt == TO_LIMIT);
    assign err       = r_err;

    // Wait counter: cleared whenever a new half request is issued, counts while waiting for ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 12'd0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= 12'd0;
        end else if ((r_state == ST_LO) || (r_state == ST_HI)) begin
            r_cnt <= r_cnt + 12'd1;
        end
    end

    // Sticky error flag: a timeout wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
    assign w_unused  = &{1'b0, err_clr, TO_LIMIT};
`endif

    // Next-state and next-output decode for the IDLE/LO/GAP/HI sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_lo_nxt       = r_lo;
        w_busy_nxt     = word_busy;
        w_req_nxt      = hw_req;
        w_we_nxt       = hw_we;
        w_hw_addr_nxt  = hw_addr;
        w_hw_wdata_nxt = hw_wdata;
        w_rdata_nxt    = word_rdata;
        case (r_state)
            ST_IDLE: begin
                if (word_wr || word_rd) begin
                    w_state_nxt    = ST_LO;
                    w_addr_nxt     = word_addr;
                    w_wdata_nxt    = word_wdata;
                    w_we_nxt       = word_wr;
                    w_busy_nxt     = 1'b1;
                    w_req_nxt      = 1'b1;
                    w_hw_addr_nxt  = {word_addr, 1'b0};
                    w_hw_wdata_nxt = word_wdata[15:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LO: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_rdata_nxt = hw_we ? word_rdata : 32'hDEAD_BEEF;
                end else if (hw_ack) begin
                    w_state_nxt = ST_GAP;
                    w_req_nxt   = 1'b0;
                    w_lo_nxt    = hw_we ? r_lo : hw_rdata;
                end else begin
                    w_state_nxt = ST_LO;
                end
            end
            ST_GAP: begin
                w_state_nxt    = ST_HI;
                w_req_nxt      = 1'b1;
                w_hw_addr_nxt  = {r_addr, 1'b1};
                w_hw_wdata_nxt = r_wdata[31:16];
            end
            ST_HI: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_rdata_nxt = hw_we ? word_rdata : 32'hDEAD_BEEF;
                end else if (hw_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_rdata_nxt = hw_we ? word_rdata : {hw_rdata, r_lo};
                end else begin
                    w_state_nxt = ST_HI;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register plus latched transaction context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 22'd0;
            r_wdata <= 32'd0;
            r_lo    <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Registered outputs; asynchronous reset drops the request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_busy  <= 1'b0;
            word_rdata <= 32'd0;
            hw_req     <= 1'b0;
            hw_we      <= 1'b0;
            hw_addr    <= 23'd0;
            hw_wdata   <= 16'd0;
        end else begin
            word_busy  <= w_busy_nxt;
            word_rdata <= w_rdata_nxt;
            hw_req     <= w_req_nxt;
            hw_we      <= w_we_nxt;
            hw_addr    <= w_hw_addr_nxt;
            hw_wdata   <= w_hw_wdata_nxt;
        end
    end

endmodule
